// File: rtl/load_value_predictor_if.sv
// Request/prediction/verification bundle between the hazard controller side (master)
// and the load value predictor (slave).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface load_value_predictor_if;
    // Valid/ready: a request transfers on a clock edge where req_valid and req_ready are both high.
    // The hazard controller stalls any request while req_ready is low.
    // Predictor outputs carry no handshake.
    // outcome_valid, mispredict and recover are single-cycle pulses that are never back-pressured.
    logic                     req_valid;
    logic                     req_is_load;
    logic [`ADDR_WIDTH-1:0]   req_pc;
    logic                     req_ready;
    logic                     pred_valid;
    logic [`DATA_WIDTH-1:0]   pred_data;
    logic                     busy;
    logic                     resp_valid;
    logic [`DATA_WIDTH-1:0]   resp_data;
    logic                     flush;
    logic                     outcome_valid;
    logic                     mispredict;
    logic                     recover;

    modport master (
        output req_valid, req_is_load, req_pc, resp_valid, resp_data, flush,
        input  req_ready, pred_valid, pred_data, busy, outcome_valid, mispredict, recover
    );

    modport slave (
        input  req_valid, req_is_load, req_pc, resp_valid, resp_data, flush,
        output req_ready, pred_valid, pred_data, busy, outcome_valid, mispredict, recover
    );
endinterface

// File: rtl/load_value_predictor.sv
// Last-value load predictor: tagged direct-mapped table, one outstanding prediction.
// Optional statistics counters are enabled by defining VP_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module load_value_predictor #(
    parameter int INDEX_BITS  = 6,
    parameter int TAG_BITS    = 8,
    parameter int CONF_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    load_value_predictor_if.slave  bus,
    output logic [1:0]             fsm_state
`ifdef VP_STATS_EN
    ,
    output logic [31:0]            stat_lookups,
    output logic [31:0]            stat_predictions,
    output logic [31:0]            stat_mispredicts
`endif
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int AW      = `ADDR_WIDTH;
    localparam int DW      = `DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ENTRIES-1:0]  valid_mem;
    logic [TAG_BITS-1:0] tag_mem   [ENTRIES];
    logic [DW-1:0]       value_mem [ENTRIES];
    logic [1:0]          conf_mem  [ENTRIES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  lookup_hit;
    logic                  lookup_issue;
    logic                  unused_pc_bits;

    logic                  load_accept;
    logic                  store_inval;
    logic                  resolve;

    logic [INDEX_BITS-1:0] lat_idx;
    logic [TAG_BITS-1:0]   lat_tag;
    logic                  lat_hit;
    logic [1:0]            lat_conf;
    logic [DW-1:0]         lat_value;
    logic                  pred_issued;
    logic                  mis_q;

    logic [DW-1:0]         upd_value;
    logic [1:0]            upd_conf;

    assign req_idx        = bus.req_pc[INDEX_BITS+1:2];
    assign req_tag        = bus.req_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign unused_pc_bits = ^{bus.req_pc[AW-1:INDEX_BITS+TAG_BITS+2], bus.req_pc[1:0]};

    assign lookup_hit   = valid_mem[req_idx] && (tag_mem[req_idx] == req_tag);
    assign lookup_issue = lookup_hit && (conf_mem[req_idx] >= 2'(CONF_THRESH));

    // flush always wins: it drops IDLE requests and aborts any verification in flight
    assign load_accept = (state == S_IDLE) && bus.req_valid && bus.req_is_load && !bus.flush;
    assign store_inval = (state == S_IDLE) && bus.req_valid && !bus.req_is_load && !bus.flush
                         && lookup_hit;
    assign resolve     = (state == S_WAIT) && bus.resp_valid && !bus.flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (load_accept) state_next = S_WAIT;
            S_WAIT: begin
                if (bus.flush) begin
                    state_next = S_IDLE;
                end else if (bus.resp_valid) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready     = (state == S_IDLE);
        bus.busy          = (state == S_WAIT);
        bus.pred_valid    = (state == S_WAIT) && pred_issued;
        bus.pred_data     = bus.pred_valid ? lat_value : '0;
        bus.outcome_valid = (state == S_DONE) && !bus.flush;
        bus.mispredict    = bus.outcome_valid && mis_q;
        bus.recover       = bus.outcome_valid && mis_q;
        fsm_state         = state;
    end

    // Lookup snapshot for the outstanding load, plus the registered verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_idx     <= '0;
            lat_tag     <= '0;
            lat_hit     <= 1'b0;
            lat_conf    <= 2'd0;
            lat_value   <= '0;
            pred_issued <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            if (load_accept) begin
                lat_idx     <= req_idx;
                lat_tag     <= req_tag;
                lat_hit     <= lookup_hit;
                lat_conf    <= conf_mem[req_idx];
                lat_value   <= value_mem[req_idx];
                pred_issued <= lookup_issue;
            end
            if (resolve) begin
                mis_q <= pred_issued && (bus.resp_data != lat_value);
            end
        end
    end

    // Stores are blocked during WAIT, so the snapshot still matches the table at resolve time
    always_comb begin
        upd_value = lat_value;
        upd_conf  = lat_conf;
        if (!lat_hit) begin
            upd_value = bus.resp_data;
            upd_conf  = 2'd0;
        end else if (bus.resp_data == lat_value) begin
            upd_conf = (lat_conf == 2'd3) ? 2'd3 : lat_conf + 2'd1;
        end else if (lat_conf == 2'd0) begin
            upd_value = bus.resp_data;
        end else begin
            upd_conf = lat_conf - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_mem <= '0;
        end else if (resolve) begin
            valid_mem[lat_idx] <= 1'b1;
        end else if (store_inval) begin
            valid_mem[req_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && resolve) begin
            tag_mem[lat_idx]   <= lat_tag;
            value_mem[lat_idx] <= upd_value;
            conf_mem[lat_idx]  <= upd_conf;
        end
    end

`ifdef VP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_predictions <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (load_accept) stat_lookups <= stat_lookups + 32'd1;
            if (load_accept && lookup_issue) stat_predictions <= stat_predictions + 32'd1;
            if (bus.recover) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/load_value_predictor.md
Name: load_value_predictor

Overview:
- Last-value predictor for load data. Sits between the D-cache request path and the hazard controller.
- On each load request it looks up a tagged, direct-mapped table by load PC. When confidence is high enough, it supplies a speculative value.
- Holds exactly one outstanding prediction. When the real D-cache data returns, it verifies the prediction and pulses a recover request on mismatch.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64).
- TAG_BITS, 8, PC tag bits stored per entry (PC[INDEX_BITS+TAG_BITS+1 : INDEX_BITS+2]).
- CONF_THRESH, 2, minimum 2-bit confidence needed to issue a prediction.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  D-cache request valid.
- req_is_load  in  1  1 = READ, 0 = WRITE.
- req_pc  in  `ADDR_WIDTH  PC of the load/store instruction.
- req_ready  out  1  high only in IDLE.
- pred_valid  out  1  speculative value available.
- pred_data  out  `DATA_WIDTH  predicted load value.
- busy  out  1  a prediction is outstanding (lock).
- resp_valid  in  1  D-cache returned real load data.
- resp_data  in  `DATA_WIDTH  real load data.
- flush  in  1  abort the outstanding prediction, no table update.
- outcome_valid  out  1  one-cycle pulse, verification finished.
- mispredict  out  1  qualified by outcome_valid.
- recover  out  1  one-cycle pulse; equals outcome_valid & mispredict.

Behaviour:
- Table entry fields: valid, tag[TAG_BITS], value[DATA_WIDTH], conf[2]. Index = req_pc[INDEX_BITS+1:2].
- Reset: state = IDLE; all valid bits cleared in one cycle. All outputs 0 except req_ready = 1. Reset mid-WAIT discards the prediction with no outcome pulse.
- State IDLE:
  - req_valid & req_is_load: latch index, tag and lookup result; go to WAIT at the next edge.
  - Hit means valid & tag match. If hit & conf >= CONF_THRESH, pred_valid = 1 and pred_data = value from the cycle after acceptance (latency 1) until WAIT exits. Otherwise pred_valid stays 0, but WAIT is still entered.
  - req_valid & !req_is_load: if the indexed entry hits, clear its valid bit at the edge. Stay in IDLE.
- State WAIT:
  - busy = 1 and req_ready = 0. Requests arriving here are ignored; the hazard controller must stall them.
  - On resp_valid, go to DONE.
  - Table update at the same edge:
    - Hit and resp_data == value: conf saturating +1 (max 3).
    - Hit and mismatch: if conf == 0, value <= resp_data; else conf -1.
    - Miss: allocate the entry with valid = 1, tag, value = resp_data, conf = 0.
  - Mispredict is registered as 1 only if a prediction was issued (pred_valid was 1) and resp_data != pred_data.
- State DONE:
  - Lasts one cycle. outcome_valid = 1, mispredict as registered, recover = mispredict. pred_valid = 0.
  - Return to IDLE next edge.
- flush:
  - In WAIT or DONE: go to IDLE next edge, no table update, no outcome pulse. This includes a flush in the same cycle as resp_valid; flush wins.
  - In IDLE: a simultaneous request is dropped.
- resp_valid in IDLE: ignored.
- Data comparison is the full DATA_WIDTH, bitwise equality.
- Conf arithmetic is 2-bit saturating, with no wrap at 0 or 3.

Optional Feature:
- Macro VP_STATS_EN.
  - Defined: adds 32-bit wrap-around counters stat_lookups, stat_predictions, stat_mispredicts. These are output ports. They increment respectively on load acceptance, prediction issue, and recover pulse, and are cleared by rst.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: load pc=0x100, resp 0xDEAD → pred_valid = 0; outcome_valid pulse with mispredict = 0; entry allocated with conf = 0.
- Training: repeat the pc=0x100 load with resp 0xDEAD ×3 → on the 3rd request pred_valid = 1 and pred_data = 0xDEAD one cycle after acceptance. Correct outcome gives no recover; conf = 3.
- Mispredict: conf = 3 entry, resp 0xBEEF → recover pulse 1 cycle, conf = 2, value still 0xDEAD.
  - Two further mismatches bring conf to 0; a third replaces value with 0xBEEF.
- Store invalidate: trained pc=0x100, then a store at pc=0x100 → the next load at 0x100 gives pred_valid = 0 and is treated as a miss.
- Flush with resp_valid in the same WAIT cycle → no outcome_valid, table unchanged, req_ready = 1 next cycle.
- Alias/tag: pc=0x100 trained, load at pc = 0x100 + (1<<(INDEX_BITS+2)) → miss, no prediction, entry reallocated with the new tag.
- Busy: a request during WAIT → ignored, busy = 1, req_ready = 0.
- Reset mid-WAIT → no outcome pulse, all entries invalid.
